// File: rtl/sipmroc_pkg.sv
// Shared constants, error codes and FSM encoding for the SiPMROC serial event link receiver.
package sipmroc_pkg;

  localparam int ADC_WIDTH       = 10;
  localparam int ADC_CHANNEL_NUM = 17;
  localparam int HDR_WIDTH       = 8;
  localparam int CNT_WIDTH       = 16;
  localparam int DATA_BITS       = ADC_WIDTH * ADC_CHANNEL_NUM;
  localparam int FRAME_BITS      = HDR_WIDTH + DATA_BITS + HDR_WIDTH;
  localparam int BIT_CNT_W       = 8;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS);

  localparam logic [HDR_WIDTH-1:0] HDR_PAT = 8'h55;
  localparam logic [HDR_WIDTH-1:0] TRL_PAT = 8'hAA;

  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;
  localparam logic [1:0] ERR_PAT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/sipmroc_sat_counter.sv
// Event counter that either wraps to zero or sticks at all-ones, selected by SATURATE.
module sipmroc_sat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk_200m,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !(SATURATE && (&count_q))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sipmroc_frame_rx.sv
// Deserializes one LSB-first SiPMROC frame per event and checks its framing.
// Optional err_count port and logic are built when SIPMROC_RX_ERRCNT_EN is defined.
module sipmroc_frame_rx
  import sipmroc_pkg::*;
(
  input  logic                 clk_200m,
  input  logic                 rst,
  input  logic                 serial_data_en,
  input  logic                 serial_data,
  output logic [DATA_BITS-1:0] event_data,
  output logic                 event_valid,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frame_count
`ifdef SIPMROC_RX_ERRCNT_EN
  ,
  output logic [CNT_WIDTH-1:0] err_count
`endif
);

  state_t                  state_q;
  logic [FRAME_BITS-1:0]   sreg_q;
  logic [BIT_CNT_W-1:0]    bit_cnt_q;
  logic [DATA_BITS-1:0]    event_data_q;
  logic                    event_valid_q;
  logic                    frame_err_q;
  logic [1:0]              err_code_q;
  // A frame already in flight when reset drops is ignored until the gate goes low.
  logic                    en_seen_low_q;

  logic pat_ok;
  logic short_err;
  logic long_err;
  logic pat_err;
  logic good_frame;

  assign pat_ok     = (sreg_q[HDR_WIDTH-1:0] == HDR_PAT) &&
                      (sreg_q[FRAME_BITS-1 -: HDR_WIDTH] == TRL_PAT);
  assign short_err  = (state_q == ST_SHIFT) && !serial_data_en && (bit_cnt_q != LAST_BIT);
  assign long_err   = (state_q == ST_SHIFT) && serial_data_en && (bit_cnt_q == LAST_BIT);
  assign pat_err    = (state_q == ST_CHECK) && !pat_ok;
  assign good_frame = (state_q == ST_CHECK) && pat_ok;

  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sreg_q        <= '0;
      bit_cnt_q     <= '0;
      event_data_q  <= '0;
      event_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'b00;
      en_seen_low_q <= 1'b0;
    end else begin
      event_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      if (!serial_data_en) begin
        en_seen_low_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (serial_data_en && en_seen_low_q) begin
            sreg_q    <= {serial_data, sreg_q[FRAME_BITS-1:1]};
            bit_cnt_q <= BIT_CNT_W'(1);
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (long_err) begin
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_LONG;
            state_q     <= ST_DRAIN;
          end else if (serial_data_en) begin
            sreg_q    <= {serial_data, sreg_q[FRAME_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end else if (short_err) begin
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_SHORT;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (pat_ok) begin
            event_data_q  <= sreg_q[FRAME_BITS-HDR_WIDTH-1:HDR_WIDTH];
            event_valid_q <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_PAT;
          end
          // Back-to-back frame: this bit already belongs to the next one.
          if (serial_data_en) begin
            sreg_q    <= {serial_data, sreg_q[FRAME_BITS-1:1]};
            bit_cnt_q <= BIT_CNT_W'(1);
            state_q   <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!serial_data_en) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign event_data  = event_data_q;
  assign event_valid = event_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != ST_IDLE);

  sipmroc_sat_counter #(
    .WIDTH    (CNT_WIDTH),
    .SATURATE (1'b0)
  ) u_frame_cnt (
    .clk_200m (clk_200m),
    .rst      (rst),
    .inc_i    (good_frame),
    .count_o  (frame_count)
  );

`ifdef SIPMROC_RX_ERRCNT_EN
  logic err_any;
  assign err_any = short_err || long_err || pat_err;

  sipmroc_sat_counter #(
    .WIDTH    (CNT_WIDTH),
    .SATURATE (1'b1)
  ) u_err_cnt (
    .clk_200m (clk_200m),
    .rst      (rst),
    .inc_i    (err_any),
    .count_o  (err_count)
  );
`endif

endmodule

// File: tb/tb_sipmroc_frame_rx.sv
// Directed and randomized checks of sipmroc_frame_rx against a frame-level reference model.
`timescale 1ns/1ps
module tb_sipmroc_frame_rx;

  logic         clk_200m = 1'b0;
  logic         rst;
  logic         serial_data_en;
  logic         serial_data;
  logic [169:0] event_data;
  logic         event_valid;
  logic         frame_err;
  logic [1:0]   err_code;
  logic         busy;
  logic [15:0]  frame_count;
`ifdef SIPMROC_RX_ERRCNT_EN
  logic [15:0]  err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_both   = 0;

  int           exp_valid  = 0;
  int           exp_err    = 0;
  logic [169:0] exp_data   = '0;
  logic [1:0]   exp_code   = 2'b00;
  int           exp_fcount = 0;
  int           exp_ecount = 0;

  always #2.5 clk_200m = ~clk_200m;

  sipmroc_frame_rx dut (
    .clk_200m       (clk_200m),
    .rst            (rst),
    .serial_data_en (serial_data_en),
    .serial_data    (serial_data),
    .event_data     (event_data),
    .event_valid    (event_valid),
    .frame_err      (frame_err),
    .err_code       (err_code),
    .busy           (busy),
    .frame_count    (frame_count)
`ifdef SIPMROC_RX_ERRCNT_EN
    ,
    .err_count      (err_count)
`endif
  );

  always @(negedge clk_200m) begin
    if (!rst) begin
      if (event_valid) n_valid++;
      if (frame_err) n_err++;
      if (event_valid && frame_err) n_both++;
    end
  end

  task automatic tick();
    @(posedge clk_200m);
    #1;
  endtask

  task automatic check(input string tag, input logic [169:0] obs, input logic [169:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [185:0] build(input logic [169:0] data);
    logic [7:0] h;
    logic [7:0] t;
    h = 8'h55;
    t = 8'hAA;
    return {t, data, h};
  endfunction

  // Frame-level model: the outcome depends only on gate length and the two patterns.
  task automatic model(input logic [185:0] f, input int n);
    logic err;
    err = 1'b1;
    if (n < 186) exp_code = 2'b01;
    else if (n > 186) exp_code = 2'b10;
    else if (f[7:0] == 8'h55 && f[185:178] == 8'hAA) begin
      err = 1'b0;
      exp_valid++;
      exp_data = f[177:8];
      exp_fcount++;
    end else exp_code = 2'b11;
    if (err) begin
      exp_err++;
      if (exp_ecount < 65535) exp_ecount++;
    end
  endtask

  task automatic send(input logic [185:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      serial_data_en = 1'b1;
      serial_data    = (i < 186) ? f[i] : 1'($urandom);
      tick();
    end
    serial_data_en = 1'b0;
    serial_data    = 1'b0;
  endtask

  task automatic verify(input string tag);
    check({tag, "_valid_pulses"}, 170'(n_valid), 170'(exp_valid));
    check({tag, "_err_pulses"}, 170'(n_err), 170'(exp_err));
    check({tag, "_both_high"}, 170'(n_both), 170'(0));
    check({tag, "_event_data"}, event_data, exp_data);
    check({tag, "_err_code"}, 170'(err_code), 170'(exp_code));
    check({tag, "_frame_count"}, 170'(frame_count), 170'(16'(exp_fcount)));
    check({tag, "_busy"}, 170'(busy), 170'(0));
`ifdef SIPMROC_RX_ERRCNT_EN
    check({tag, "_err_count"}, 170'(err_count), 170'(16'(exp_ecount)));
`endif
  endtask

  initial begin
    logic [169:0] d;
    logic [185:0] f;
    logic [185:0] g;
    int           n;
    int           kind;
    int           pos;

    rst            = 1'b1;
    serial_data_en = 1'b0;
    serial_data    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tick();
    verify("reset");
    check("reset_event_valid", 170'(event_valid), 170'(0));
    check("reset_frame_err", 170'(frame_err), 170'(0));

    // 1: good frame, ch k = 3k+1, with exact latency
    for (int k = 0; k < 17; k++) d[10*k +: 10] = 10'(3*k + 1);
    f = build(d);
    model(f, 186);
    send(f, 186);
    $display("txn 1 good frame bits=186");
    check("t1_busy_last_bit", 170'(busy), 170'(1));
    tick();
    check("t1_valid_early", 170'(event_valid), 170'(0));
    check("t1_busy_check", 170'(busy), 170'(1));
    tick();
    check("t1_valid", 170'(event_valid), 170'(1));
    check("t1_frame_err", 170'(frame_err), 170'(0));
    check("t1_ch0", 170'(event_data[9:0]), 170'(1));
    check("t1_ch16", 170'(event_data[169:160]), 170'(49));
    check("t1_frame_count", 170'(frame_count), 170'(1));
    repeat (3) tick();
    verify("t1");

    // 2: short frame
    f = build(170'($urandom));
    model(f, 100);
    send(f, 100);
    $display("txn 2 short frame bits=100");
    tick();
    check("t2_frame_err", 170'(frame_err), 170'(1));
    check("t2_err_code", 170'(err_code), 170'(2'b01));
    check("t2_busy", 170'(busy), 170'(0));
    repeat (3) tick();
    verify("t2");

    // 3: long frame
    model(f, 190);
    send(f, 190);
    $display("txn 3 long frame bits=190");
    check("t3_busy_drain", 170'(busy), 170'(1));
    tick();
    check("t3_busy_after", 170'(busy), 170'(0));
    repeat (3) tick();
    verify("t3");

    // 4: first header bit flipped
    f = build(d);
    f[0] = 1'b0;
    model(f, 186);
    send(f, 186);
    $display("txn 4 header bit0 flipped");
    repeat (4) tick();
    verify("t4");

    // 5: two good frames with a 1-cycle gap
    for (int k = 0; k < 17; k++) d[10*k +: 10] = 10'($urandom);
    f = build(d);
    for (int k = 0; k < 17; k++) d[10*k +: 10] = 10'($urandom);
    g = build(d);
    model(f, 186);
    model(g, 186);
    send(f, 186);
    tick();
    send(g, 186);
    $display("txn 5 back-to-back good frames");
    repeat (4) tick();
    verify("t5");

    // 6: reset at bit 90, gate stays high through the rest of the frame
    f = build(170'($urandom));
    for (int i = 0; i < 90; i++) begin
      serial_data_en = 1'b1;
      serial_data    = f[i];
      tick();
    end
    #0.5 rst = 1'b1;
    #1.5 rst = 1'b0;
    exp_data   = '0;
    exp_code   = 2'b00;
    exp_fcount = 0;
    exp_ecount = 0;
    check("t6_reset_frame_count", 170'(frame_count), 170'(0));
    check("t6_reset_event_data", event_data, 170'(0));
    for (int i = 90; i < 186; i++) begin
      serial_data_en = 1'b1;
      serial_data    = f[i];
      tick();
    end
    serial_data_en = 1'b0;
    repeat (3) tick();
    verify("t6_discard");
    f = build(170'($urandom));
    model(f, 186);
    send(f, 186);
    $display("txn 6 reset mid-frame then good frame");
    repeat (4) tick();
    verify("t6");

    // randomized frames
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 17; k++) d[10*k +: 10] = 10'($urandom);
      f    = build(d);
      kind = $urandom_range(0, 3);
      n    = 186;
      if (kind == 1) n = $urandom_range(1, 185);
      else if (kind == 2) n = $urandom_range(187, 200);
      else if (kind == 3) begin
        pos = $urandom_range(0, 15);
        pos = (pos < 8) ? pos : pos + 170;
        f[pos] = ~f[pos];
      end
      model(f, n);
      send(f, n);
      $display("txn rnd%0d kind=%0d bits=%0d", t, kind, n);
      repeat (4) tick();
      verify($sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
